// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential floating-point multiplier built around an iterative
// radix-4 Booth significand multiplier. Zero and subnormal operands are flushed
// to zero. Inf/NaN operands return a canonical quiet NaN.
// Optional feature macro: FPM_RNE_EN. When it is defined, NORM rounds to
// nearest-even. When it is undefined, NORM truncates.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high (once out of reset)
// MUL   | one Booth partial product accumulated per cycle
// NORM  | normalise, round, range-check; result registers loaded
// DONE  | result held until out_ready (special cases load it here first)
module fp_mult_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_product,
   output logic [1:0]           out_flag
);
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int S     = MAN_W + 1;
   localparam int P     = 2 * S;
   localparam int STEPS = (S + 2) / 2;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam int EW    = EXP_W + 2;
   localparam int BIAS  = 2**(EXP_W-1) - 1;
   localparam int EMAX  = 2**EXP_W - 1;

   localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
   localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

   localparam logic [1:0] FLAG_NORM = 2'b00;
   localparam logic [1:0] FLAG_OVF  = 2'b01;
   localparam logic [1:0] FLAG_UNF  = 2'b10;
   localparam logic [1:0] FLAG_INV  = 2'b11;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
   state_t state, state_nxt;

   logic signed [P-1:0]  acc;
   logic [P-1:0]         mcand;
   logic [S+1:0]         mplier;
   logic [CNT_W-1:0]     cnt;
   logic signed [EW-1:0] exp_sum;
   logic                 sign_r;
   logic                 nan_r;
   logic                 started;

   logic                 accept;
   logic                 in_nan;
   logic                 in_zero;
   logic signed [EW-1:0] exp_calc;
   logic signed [P-1:0]  pp;

   logic                 hi;
   logic [MAN_W-1:0]     man_t;
   logic [MAN_W-1:0]     man_f;
   logic signed [EW-1:0] exp_f;
   logic [W-1:0]         norm_res;
   logic [1:0]           norm_flag;
`ifdef FPM_RNE_EN
   logic                 guard;
   logic                 sticky;
   logic                 rnd;
   logic [MAN_W:0]       man_sum;
`endif

   // in_ready stays low until the first clock edge after reset is released.
   assign in_ready = (state == IDLE) && started;
   assign accept   = in_valid && in_ready;

   // Classify the incoming operands and form the biased result exponent.
   always_comb begin
      in_nan   = (&in_a[W-2 -: EXP_W]) | (&in_b[W-2 -: EXP_W]);
      in_zero  = (in_a[W-2 -: EXP_W] == '0) | (in_b[W-2 -: EXP_W] == '0);
      exp_calc = $signed({2'b00, in_a[W-2 -: EXP_W]})
               + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_S;
   end

   // Select the Booth digit from the low 3-bit window of the multiplier.
   always_comb begin
      pp = '0;
      case (mplier[2:0])
         3'b001, 3'b010: pp = $signed(mcand);
         3'b011:         pp = $signed(mcand << 1);
         3'b100:         pp = -$signed(mcand << 1);
         3'b101, 3'b110: pp = -$signed(mcand);
         default:        pp = '0;
      endcase
   end

   // Normalise, optionally round, and apply the exponent range checks.
   always_comb begin
      hi    = acc[P-1];
      man_t = hi ? acc[P-2 -: MAN_W] : acc[P-3 -: MAN_W];
      exp_f = exp_sum + $signed({{(EW-1){1'b0}}, hi});
`ifdef FPM_RNE_EN
      guard   = hi ? acc[S-1] : acc[S-2];
      sticky  = hi ? (|acc[S-2:0]) : (|acc[S-3:0]);
      rnd     = guard & (sticky | man_t[0]);
      man_sum = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
      man_f   = man_sum[MAN_W-1:0];
      // A mantissa carry means the significand reached 2.0, so renormalise.
      exp_f   = exp_f + $signed({{(EW-1){1'b0}}, man_sum[MAN_W]});
`else
      man_f   = man_t;
`endif
      norm_res  = {sign_r, exp_f[EXP_W-1:0], man_f};
      norm_flag = FLAG_NORM;
      if (exp_f >= EMAX_S) begin
         norm_res  = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         norm_flag = FLAG_OVF;
      end else if (exp_f <= $signed({EW{1'b0}})) begin
         norm_res  = {sign_r, {(W-1){1'b0}}};
         norm_flag = FLAG_UNF;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (in_nan || in_zero) ? DONE : MUL;
         MUL:  if (cnt == '0) state_nxt = NORM;
         NORM: state_nxt = DONE;
         DONE: if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, Booth accumulation, result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started     <= 1'b0;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         cnt         <= '0;
         exp_sum     <= '0;
         sign_r      <= 1'b0;
         nan_r       <= 1'b0;
         out_valid   <= 1'b0;
         out_product <= '0;
         out_flag    <= FLAG_NORM;
      end else begin
         started <= 1'b1;
         case (state)
            IDLE: if (accept) begin
               mcand   <= P'({1'b1, in_a[MAN_W-1:0]});
               mplier  <= {1'b0, 1'b1, in_b[MAN_W-1:0], 1'b0};
               acc     <= '0;
               cnt     <= CNT_W'(STEPS - 1);
               exp_sum <= exp_calc;
               sign_r  <= in_a[W-1] ^ in_b[W-1];
               nan_r   <= in_nan;
            end
            MUL: begin
               acc    <= acc + pp;
               mcand  <= mcand << 2;
               mplier <= {{2{mplier[S+1]}}, mplier[S+1:2]};
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            NORM: begin
               out_product <= norm_res;
               out_flag    <= norm_flag;
               out_valid   <= 1'b1;
            end
            DONE: begin
               // Special cases arrive here with out_valid low; load their result now.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  if (nan_r) begin
                     out_product <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                     out_flag    <= FLAG_INV;
                  end else begin
                     out_product <= {sign_r, {(W-1){1'b0}}};
                     out_flag    <= FLAG_NORM;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: checks fp_mult_seq (EXP_W=5, MAN_W=10) against a plain
// arithmetic model of half-precision multiplication, plus literal vectors.
module tb_fp_mult_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_product;
   logic [1:0]  out_flag;

   int checks = 0;
   int errors = 0;
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   fp_mult_seq #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .out_flag(out_flag)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: exact integer product of the significands, then scale by powers of two.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
      int     ea, eb, e, shift;
      longint sa, sb, prod, man;
      logic   s;
`ifdef FPM_RNE_EN
      longint rem, half;
`endif
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      s  = a[15] ^ b[15];
      if (ea == 31 || eb == 31) return {16'h7E00, 2'b11};
      if (ea == 0 || eb == 0)   return {s, 15'h0, 2'b00};
      sa   = 1024 + longint'(a[9:0]);
      sb   = 1024 + longint'(b[9:0]);
      prod = sa * sb;
      e    = ea + eb - 15;
      if (prod >= 64'd2097152) begin shift = 11; e = e + 1; end
      else shift = 10;
      man = (prod >> shift) - 1024;
`ifdef FPM_RNE_EN
      rem  = prod - ((prod >> shift) << shift);
      half = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && (man % 2) == 1)) man = man + 1;
      if (man == 1024) begin man = 0; e = e + 1; end
`endif
      if (e >= 31) return {s, 5'h1F, 10'h0, 2'b01};
      if (e <= 0)  return {s, 15'h0, 2'b10};
      return {s, 5'(e), 10'(man), 2'b00};
   endfunction

   function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
      return (a[14:10] == 5'h1F) || (b[14:10] == 5'h1F) ||
             (a[14:10] == 5'h00) || (b[14:10] == 5'h00);
   endfunction

   // Compare process: every cycle a result is presented it must match the model.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            chk("stream_product", 32'(out_product), 32'(exp_q[0][17:2]));
            chk("stream_flag", 32'(out_flag), 32'(exp_q[0][1:0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic op(input logic [15:0] a, input logic [15:0] b, input int stall,
                     output int lat, output logic [15:0] prod, output logic [1:0] flag);
      int n;
      logic [17:0] m;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("ready_before_op", 32'(in_ready), 32'd1);
      m = model(a, b);
      exp_q.push_back(m);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      prod = out_product;
      flag = out_flag;
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_product", 32'(out_product), 32'(m[17:2]));
            chk("stall_flag", 32'(out_flag), 32'(m[1:0]));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("ready_after_handshake", 32'(in_ready), 32'd1);
      chk("valid_after_handshake", 32'(out_valid), 32'd0);
   endtask

   logic [15:0] va[8] = '{16'h4000, 16'hC000, 16'h3E00, 16'h3E01, 16'h7BFF, 16'h0400, 16'h7C00, 16'h0000};
   logic [15:0] vb[8] = '{16'h4200, 16'h4200, 16'h3E00, 16'h3C01, 16'h7BFF, 16'h0400, 16'h3C00, 16'h4000};
`ifdef FPM_RNE_EN
   logic [15:0] vp[8] = '{16'h4600, 16'hC600, 16'h4080, 16'h3E03, 16'h7C00, 16'h0000, 16'h7E00, 16'h0000};
`else
   logic [15:0] vp[8] = '{16'h4600, 16'hC600, 16'h4080, 16'h3E02, 16'h7C00, 16'h0000, 16'h7E00, 16'h0000};
`endif
   logic [1:0]  vf[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
   int          vl[8] = '{7, 7, 7, 7, 7, 7, 1, 1};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [15:0] p, a, b;
      logic [1:0]  f;
      logic [17:0] m;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_product", 32'(out_product), 32'd0);
      chk("rst_out_flag", 32'(out_flag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ready_before_first_edge", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("ready_first_edge", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         m = model(va[i], vb[i]);
         chk("model_pin", 32'(m), 32'({vp[i], vf[i]}));
         op(va[i], vb[i], (i == 0) ? 5 : 0, lat, p, f);
         chk("lit_product", 32'(p), 32'(vp[i]));
         chk("lit_flag", 32'(f), 32'(vf[i]));
         chk("lit_latency", 32'(lat), 32'(vl[i]));
      end

      // Produce a non-zero result first so the reset clear is observable.
      op(16'h4000, 16'h4200, 0, lat, p, f);
      in_a = 16'h4000; in_b = 16'h4200; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_product", 32'(out_product), 32'd0);
      chk("abort_out_flag", 32'(out_flag), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("abort_hold_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready_after_release", 32'(in_ready), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("abort_no_valid", 32'(out_valid), 32'd0);
      end
      op(16'h4000, 16'h4200, 0, lat, p, f);
      chk("post_abort_product", 32'(p), 32'h4600);
      chk("post_abort_latency", 32'(lat), 32'd7);

      for (int i = 0; i < 300; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 9) != 0) a[14:10] = 5'($urandom_range(1, 30));
         if ($urandom_range(0, 9) != 0) b[14:10] = 5'($urandom_range(1, 30));
         op(a, b, $urandom_range(0, 2), lat, p, f);
         chk("rand_latency", 32'(lat), is_special(a, b) ? 32'd1 : 32'd7);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp_mult_seq.md
FP_MULT_SEQ -- requirements
Module: fp_mult_seq

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width; the bias SHALL be 2^(EXP_W-1)-1.
REQ-002 Parameter MAN_W, default 10, stored mantissa width; significand S = MAN_W+1 bits with hidden 1.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}.
REQ-008 in_b  input  1+EXP_W+MAN_W  operand B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_product  output  1+EXP_W+MAN_W  result.
REQ-012 out_flag  output  2  00 normal, 01 overflow, 10 underflow, 11 invalid (Inf/NaN operand).

Function
REQ-013 FSM states IDLE, MUL, NORM, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept on in_valid && in_ready: register both operands; IDLE->MUL, or IDLE->DONE for special cases.
REQ-015 Special-case priority: any exp all-ones -> out_product {0, all-ones exp, 1, zeros}, flag 11; else any exp = 0 (zero or subnormal, flushed) -> {sign, zeros}, flag 00.
REQ-016 Special cases SHALL assert out_valid 1 cycle after the accept edge.
REQ-017 MUL SHALL run an iterative radix-4 Booth multiply of the two significands, zero-extended to S+1 bits: one partial product per cycle, STEPS = ceil((S+1)/2) cycles, 2S-bit accumulator.
REQ-018 Partial-product digits: 0, +M, +2M, -2M, -M, taken from a 3-bit overlapping window; the accumulator SHALL be sign-extended.
REQ-019 Sign = sign_a XOR sign_b; the unbiased exponent sum SHALL be computed in EXP_W+2-bit signed arithmetic.
REQ-020 NORM (1 cycle): if product bit 2S-1 = 1, take mantissa from bits [2S-2 -: MAN_W] and add 1 to the exponent; else take bits [2S-3 -: MAN_W].
REQ-021 Default rounding SHALL be truncation.
REQ-022 Overflow: final exponent >= 2^EXP_W-1 -> {sign, all-ones exp, zeros}, flag 01.
REQ-023 Underflow: final exponent <= 0 -> {sign, zeros}, flag 10.
REQ-024 Normal-path latency SHALL be STEPS+1 cycles from accept edge to out_valid (7 for defaults).
REQ-025 DONE: out_valid=1; out_product and out_flag SHALL stay stable until out_valid && out_ready.
REQ-026 Handshake completion -> IDLE; in_ready rises on the following cycle, so no same-cycle re-accept.
REQ-027 in_a and in_b changes outside the accept cycle SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=0 while asserted, out_valid=0, out_product=0, out_flag=00, accumulator and counter 0.
REQ-029 Reset mid-operation SHALL abort it; no result is emitted for that operation.
REQ-030 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-031 Macro FPM_RNE_EN defined: NORM SHALL apply round-to-nearest-even using guard and sticky bits; a mantissa carry SHALL renormalise (exponent+1) before the overflow check, with latency unchanged.
REQ-032 FPM_RNE_EN undefined: truncation only, and no rounding logic is present.

Verification (defaults EXP_W=5, MAN_W=10)
REQ-033 0x4000 x 0x4200 -> 0x4600, flag 00, out_valid 7 cycles after accept; 0xC000 x 0x4200 -> 0xC600.
REQ-034 0x3E00 x 0x3E00 -> 0x4080 (normalisation shift); 0x3E01 x 0x3C01 -> 0x3E02 without FPM_RNE_EN, 0x3E03 with it.
REQ-035 0x7BFF x 0x7BFF -> 0x7C00, flag 01; 0x0400 x 0x0400 -> 0x0000, flag 10.
REQ-036 0x7C00 x 0x3C00 -> 0x7E00, flag 11, 1-cycle latency; 0x0000 x 0x4000 -> 0x0000, flag 00.
REQ-037 out_ready held low 5 cycles in DONE -> out_valid, out_product and in_ready stable; in_ready=1 one cycle after release.
REQ-038 rst_n pulsed low during MUL -> outputs clear at once, no out_valid follows, and the next operation completes correctly.
